// File: rtl/p1_sprite_fetch.sv
// Player-1 sprite fetch: prefetches the next scanline's 32-pixel sprite row into a
// 16-word line buffer during hblank, then streams registered colour indices in active video.
module p1_sprite_fetch #(
    parameter int         H_ACTIVE    = 640,
    parameter int         V_ACTIVE    = 480,
    parameter int         V_TOTAL     = 525,
    parameter int         SPR_W       = 32,
    parameter int         SPR_H       = 32,
    parameter logic [7:0] TRANSPARENT = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_ce,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        frame_start,
    input  logic [10:0] sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic        sprite_en,
    output logic [8:0]  mem_address,
    output logic        mem_chipselect,
    output logic        mem_clken,
    input  logic [15:0] mem_readdata,
    output logic [7:0]  pixel_index,
    output logic        pixel_opaque,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [10:0] LP_H_ACTIVE = 11'(H_ACTIVE);
    localparam logic [9:0]  LP_V_ACTIVE = 10'(V_ACTIVE);
    localparam logic [9:0]  LP_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  LP_SPR_H    = 10'(SPR_H);
    localparam logic [10:0] LP_SPR_W    = 11'(SPR_W);

    state_t      r_state;
    state_t      w_next;
    logic [10:0] r_x_lat;
    logic [9:0]  r_y_lat;
    logic        r_en_lat;
    logic [3:0]  r_k;
    logic [4:0]  r_row;
    logic        r_drain2;
    logic        r_buf_valid;
    logic        r_cap_valid;
    logic [3:0]  r_cap_idx;
    logic [15:0] r_linebuf [16];
    logic [7:0]  r_pixel_index;
    logic        r_pixel_opaque;

    logic [9:0]  w_y_eff;
    logic        w_en_eff;
    logic [9:0]  w_nl;
    logic [9:0]  w_row;
    logic        w_row_hit;
    logic        w_trigger;
    logic [10:0] w_col;
    logic [15:0] w_word;
    logic [7:0]  w_byte;
    logic        w_pix_hit;

    // A frame_start coinciding with the fetch trigger must already see the new position.
    assign w_y_eff   = frame_start ? sprite_y  : r_y_lat;
    assign w_en_eff  = frame_start ? sprite_en : r_en_lat;
    assign w_nl      = (vcount == LP_V_LAST) ? 10'd0 : vcount + 10'd1;
    assign w_row     = w_nl - w_y_eff;
    assign w_row_hit = w_en_eff && (w_row < LP_SPR_H) && (w_nl < LP_V_ACTIVE);
    assign w_trigger = pix_ce && (hcount == LP_H_ACTIVE);

    assign w_col     = hcount - r_x_lat;
    assign w_word    = r_linebuf[w_col[4:1]];
    assign w_byte    = w_col[0] ? w_word[15:8] : w_word[7:0];
    assign w_pix_hit = r_buf_valid && (w_col < LP_SPR_W) && (hcount < LP_H_ACTIVE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger && w_row_hit) w_next = S_FETCH;
            S_FETCH: if (r_k == 4'd15) w_next = S_DRAIN;
            S_DRAIN: if (r_drain2) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign mem_address    = (r_state == S_FETCH) ? {r_row, r_k} : 9'd0;
    assign mem_chipselect = (r_state == S_FETCH);
    assign mem_clken      = 1'b1;
    assign busy           = (r_state != S_IDLE);
    assign dbg_state      = r_state;
    assign pixel_index    = r_pixel_index;
    assign pixel_opaque   = r_pixel_opaque;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_x_lat        <= '0;
            r_y_lat        <= '0;
            r_en_lat       <= 1'b0;
            r_k            <= '0;
            r_row          <= '0;
            r_drain2       <= 1'b0;
            r_buf_valid    <= 1'b0;
            r_cap_valid    <= 1'b0;
            r_cap_idx      <= '0;
            r_pixel_index  <= '0;
            r_pixel_opaque <= 1'b0;
        end else begin
            r_state <= w_next;
            if (frame_start) begin
                r_x_lat  <= sprite_x;
                r_y_lat  <= sprite_y;
                r_en_lat <= sprite_en;
            end
            if (r_state == S_IDLE && w_trigger) begin
                r_buf_valid <= 1'b0;
                r_k         <= 4'd0;
                if (w_row_hit) r_row <= w_row[4:0];
            end
            if (r_state == S_FETCH) r_k <= r_k + 4'd1;
            // Read data lags the address by one clk, so the write index trails k.
            r_cap_valid <= (r_state == S_FETCH);
            r_cap_idx   <= r_k;
            if (r_state == S_DRAIN) begin
                r_drain2 <= ~r_drain2;
                if (r_drain2) r_buf_valid <= 1'b1;
            end
            if (pix_ce) begin
                r_pixel_index  <= w_pix_hit ? w_byte : 8'd0;
                r_pixel_opaque <= w_pix_hit && (w_byte != TRANSPARENT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_cap_valid) r_linebuf[r_cap_idx] <= mem_readdata;
    end

endmodule

// File: tb/tb_p1_sprite_fetch.sv
// Directed bench for p1_sprite_fetch: sprite memory model, hand-computed fetch
// addresses, pixel values, clipping, position latching and mid-fetch reset.
module tb_p1_sprite_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pix_ce;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        frame_start;
    logic [10:0] sprite_x;
    logic [9:0]  sprite_y;
    logic        sprite_en;
    logic [8:0]  mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic [15:0] mem_readdata;
    logic [7:0]  pixel_index;
    logic        pixel_opaque;
    logic        busy;
    logic [1:0]  dbg_state;

    logic [15:0] mem [512];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem[mem_address];
    end

    p1_sprite_fetch dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pix_ce         (pix_ce),
        .hcount         (hcount),
        .vcount         (vcount),
        .frame_start    (frame_start),
        .sprite_x       (sprite_x),
        .sprite_y       (sprite_y),
        .sprite_en      (sprite_en),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .pixel_index    (pixel_index),
        .pixel_opaque   (pixel_opaque),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [9:0] v, input logic [10:0] h);
        vcount = v;
        hcount = h;
        pix_ce = 1'b1;
        tick();
        pix_ce = 1'b0;
    endtask

    task automatic frame(input logic [10:0] x, input logic [9:0] y, input logic en);
        sprite_x    = x;
        sprite_y    = y;
        sprite_en   = en;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Trigger at hcount=640 of line v and check the 16 addresses plus the 18-clk busy window.
    task automatic run_fetch(input logic [9:0] v, input logic [8:0] base,
                             input logic fs, input logic [9:0] fy);
        int cnt;
        vcount = v;
        hcount = 11'd640;
        pix_ce = 1'b1;
        if (fs) begin
            sprite_y    = fy;
            frame_start = 1'b1;
        end
        tick();
        pix_ce      = 1'b0;
        frame_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("fetch_addr", 32'(mem_address), 32'(base) + 32'(i));
            if (i == 0) chk("fetch_cs", 32'(mem_chipselect), 32'd1);
            tick();
        end
        cnt = 16;
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("busy_len", 32'(cnt), 32'd18);
        chk("cs_after", 32'(mem_chipselect), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[9'h000] = 16'hAB12;
        mem[9'h009] = 16'h3344;
        mem[9'h00F] = 16'h7700;
        mem[9'h050] = 16'h0012;
        mem[9'h090] = 16'h5501;
        mem_readdata = 16'h0000;
        reset_n     = 1'b0;
        pix_ce      = 1'b0;
        hcount      = '0;
        vcount      = '0;
        frame_start = 1'b0;
        sprite_x    = '0;
        sprite_y    = '0;
        sprite_en   = 1'b0;
        tick();
        tick();
        chk("rst_index",  32'(pixel_index),    32'h0);
        chk("rst_opaque", 32'(pixel_opaque),   32'h0);
        chk("rst_busy",   32'(busy),           32'h0);
        chk("rst_addr",   32'(mem_address),    32'h0);
        chk("rst_cs",     32'(mem_chipselect), 32'h0);
        chk("rst_clken",  32'(mem_clken),      32'h1);
        chk("rst_state",  32'(dbg_state),      32'h0);
        reset_n = 1'b1;
        tick();

        // Basic fetch of row 0 and pixel decode on line 100.
        frame(11'd200, 10'd100, 1'b1);
        run_fetch(10'd99, 9'h000, 1'b0, 10'd0);
        pix(10'd100, 11'd199);
        chk("px199_op",  32'(pixel_opaque), 32'h0);
        pix(10'd100, 11'd200);
        chk("px200_idx", 32'(pixel_index),  32'h12);
        chk("px200_op",  32'(pixel_opaque), 32'h1);
        pix(10'd100, 11'd201);
        chk("px201_idx", 32'(pixel_index),  32'hAB);
        chk("px201_op",  32'(pixel_opaque), 32'h1);
        hcount = 11'd232;
        tick();
        chk("hold_idx",  32'(pixel_index),  32'hAB);
        pix(10'd100, 11'd230);
        chk("px230_op",  32'(pixel_opaque), 32'h0);
        pix(10'd100, 11'd231);
        chk("px231_idx", 32'(pixel_index),  32'h77);
        chk("px231_op",  32'(pixel_opaque), 32'h1);
        pix(10'd100, 11'd232);
        chk("px232_idx", 32'(pixel_index),  32'h0);
        chk("px232_op",  32'(pixel_opaque), 32'h0);

        // Row 5: odd pixel is transparent.
        run_fetch(10'd104, 9'h050, 1'b0, 10'd0);
        pix(10'd105, 11'd200);
        chk("r5_even_idx", 32'(pixel_index),  32'h12);
        chk("r5_even_op",  32'(pixel_opaque), 32'h1);
        pix(10'd105, 11'd201);
        chk("r5_odd_idx",  32'(pixel_index),  32'h0);
        chk("r5_odd_op",   32'(pixel_opaque), 32'h0);

        // Right-edge clipping, no wrap to the left edge.
        frame(11'd620, 10'd100, 1'b1);
        run_fetch(10'd99, 9'h000, 1'b0, 10'd0);
        pix(10'd100, 11'd620);
        chk("re620_idx", 32'(pixel_index),  32'h12);
        chk("re620_op",  32'(pixel_opaque), 32'h1);
        pix(10'd100, 11'd639);
        chk("re639_idx", 32'(pixel_index),  32'h33);
        chk("re639_op",  32'(pixel_opaque), 32'h1);
        for (int h = 0; h < 12; h++) begin
            pix(10'd101, 11'(h));
            chk("re_wrap_op", 32'(pixel_opaque), 32'h0);
        end

        // Bottom-edge clipping: row 9 on line 479, nothing for line 480.
        frame(11'd200, 10'd470, 1'b1);
        run_fetch(10'd478, 9'h090, 1'b0, 10'd0);
        pix(10'd479, 11'd200);
        chk("be479_idx", 32'(pixel_index),  32'h01);
        chk("be479_op",  32'(pixel_opaque), 32'h1);
        pix(10'd479, 11'd640);
        chk("be_no_fetch", 32'(busy), 32'h0);
        pix(10'd480, 11'd200);
        chk("be_buf_clr", 32'(pixel_opaque), 32'h0);

        // Mid-frame sprite_y change is ignored until frame_start.
        frame(11'd200, 10'd100, 1'b1);
        sprite_y = 10'd300;
        run_fetch(10'd99, 9'h000, 1'b0, 10'd0);
        pix(10'd100, 11'd200);
        chk("mf_idx", 32'(pixel_index),  32'h12);
        chk("mf_op",  32'(pixel_opaque), 32'h1);
        pix(10'd299, 11'd640);
        chk("mf_no_fetch", 32'(busy), 32'h0);

        // y=0: line 0 is fetched during the last line of the frame.
        frame(11'd200, 10'd0, 1'b1);
        run_fetch(10'd524, 9'h000, 1'b0, 10'd0);
        pix(10'd0, 11'd201);
        chk("l0_idx", 32'(pixel_index),  32'hAB);
        chk("l0_op",  32'(pixel_opaque), 32'h1);

        // frame_start coincident with the trigger uses the new y.
        run_fetch(10'd49, 9'h000, 1'b1, 10'd50);
        pix(10'd50, 11'd200);
        chk("sim_idx", 32'(pixel_index), 32'h12);

        // Reset during the 5th fetch cycle.
        frame(11'd200, 10'd100, 1'b1);
        vcount = 10'd99;
        hcount = 11'd640;
        pix_ce = 1'b1;
        tick();
        pix_ce = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_addr", 32'(mem_address), 32'h004);
        reset_n = 1'b0;
        #1;
        chk("arst_cs",     32'(mem_chipselect), 32'h0);
        chk("arst_busy",   32'(busy),           32'h0);
        chk("arst_opaque", 32'(pixel_opaque),   32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        frame(11'd200, 10'd100, 1'b1);
        pix(10'd100, 11'd200);
        chk("arst_no_pix", 32'(pixel_opaque), 32'h0);
        chk("arst_idle",   32'(busy),         32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/p1_sprite_fetch.md
Name: p1_sprite_fetch

Overview:
Streams sprite pixels from the 512x16 player-1 sprite memory into the VGA pixel pipeline. The sprite is 32x32 at 8 bits per pixel, packed two pixels per 16-bit word, 16 words per row. During horizontal blanking the block prefetches the next scanline's sprite row into a 16x16 line buffer. During active video it emits a per-pixel colour index with a valid/opaque flag to the downstream compositor.

Parameters:
H_ACTIVE, 640, visible pixels per line; the fetch is triggered when hcount equals this value
V_ACTIVE, 480, visible lines per frame
V_TOTAL, 525, total lines per frame, used for next-line wrap
SPR_W, 32, sprite width in pixels (fixed; 16 words per row)
SPR_H, 32, sprite height in lines
TRANSPARENT, 8'h00, colour index treated as transparent

Ports:
clk  in  1  system clock; memory and pixel pipeline share it
reset_n  in  1  asynchronous active-low reset
pix_ce  in  1  pixel strobe; hcount/vcount advance only on cycles where it is 1
hcount  in  11  current pixel column
vcount  in  10  current line
frame_start  in  1  single-cycle pulse at the start of vertical blank
sprite_x  in  11  requested sprite left edge; sampled on frame_start
sprite_y  in  10  requested sprite top line; sampled on frame_start
sprite_en  in  1  sprite visible; sampled on frame_start
mem_address  out  9  sprite memory word address
mem_chipselect  out  1  read strobe to sprite memory
mem_clken  out  1  sprite memory clock enable
mem_readdata  in  16  sprite memory data, valid one clk after the address is presented
pixel_index  out  8  colour index for the current pixel
pixel_opaque  out  1  1 when the sprite covers this pixel and the index is not TRANSPARENT
busy  out  1  1 while a row fetch is in progress

Behaviour:
- Reset values: pixel_index=0, pixel_opaque=0, busy=0, mem_address=0, mem_chipselect=0, mem_clken=1. Latched x/y/en are 0. Line buffer is invalid. FSM is in IDLE.
- Position latch: sprite_x, sprite_y and sprite_en are captured only on frame_start. Mid-frame changes to these inputs have no effect until the next frame_start.
- Next line: nl = vcount+1, wrapping to 0 when vcount = V_TOTAL-1. row = nl - y_lat, computed in 10 bits. The row hits when en_lat=1, row < SPR_H, and nl < V_ACTIVE.
- IDLE: on pix_ce with hcount = H_ACTIVE:
  - row hits: go to FETCH, set k=0, clear buf_valid.
  - row misses: clear buf_valid and stay in IDLE.
- FETCH: one read per clk, independent of pix_ce.
  - Drive mem_address = {row[4:0], k[3:0]}, mem_chipselect=1.
  - The word returned one clk later is written to linebuf[k_prev].
  - After k=15 is issued, go to DRAIN.
- DRAIN: one clk to capture word 15, then set buf_valid=1 and return to IDLE.
- busy=1 in FETCH and DRAIN. A fetch completes in 18 clk, well inside any hblank.
- Pixel path: on pix_ce, col = hcount - x_lat, computed in 11 bits.
  - Hit: buf_valid=1, col < 32 and hcount < H_ACTIVE.
  - word = linebuf[col[4:1]]. The byte is word[7:0] when col[0]=0, word[15:8] when col[0]=1.
  - Outputs are registered one clk after the pix_ce cycle: pixel_index=byte, pixel_opaque = hit && byte != TRANSPARENT.
  - On a miss, pixel_index=0 and pixel_opaque=0.
  - Outputs hold when pix_ce=0.
- Right-edge clipping: x_lat > H_ACTIVE-32 shows only the visible columns; no wrap to the left edge.
- Bottom-edge clipping: y_lat > V_ACTIVE-32 fetches only rows with nl < V_ACTIVE.
- Line 0: vcount = V_TOTAL-1 wraps to nl=0, so line 0 is fetched during the last blank line.
- Simultaneous frame_start and fetch trigger: the fetch uses the new latched values.
- frame_start during FETCH: the fetch completes with the row already computed.
- Reset mid-fetch: the FSM aborts to IDLE, buf_valid clears, mem_chipselect drops immediately.
- Memory writes are never issued by this block.

Test Plan:
- y=100, x=200, en=1, frame_start, then run line 99 to hcount=640 -> mem_address issues 9'h000..9'h00F in 16 consecutive clk, busy high 18 clk, buf_valid set.
- Preload word 0 = 16'hAB12; on line 100 -> at hcount=200 pixel_index=8'h12 and at 201 pixel_index=8'hAB, both opaque=1, each 1 clk after pix_ce. hcount=199 and 232 give opaque=0.
- Word 16'h0012 at row 5 -> line y+5 addresses 0x050-0x05F; the odd pixel reports index 0 with opaque=0 (transparent).
- x=620 -> columns 620..639 drawn, no opaque pixel at hcount 0..11 of the next line; y=470 -> rows 0..9 fetched, no fetch triggered on line 479.
- Change sprite_y mid-frame without frame_start -> output unchanged. Pulse frame_start -> new position from the next frame. y=0 -> fetch occurs on line V_TOTAL-1.
- Assert reset_n=0 at the 5th fetch cycle -> mem_chipselect=0 and busy=0 asynchronously, pixel_opaque=0, no pixels on that line.
